// File: rtl/time_report_pkg.sv
// Shared types and ASCII constants for the time-report frame sequencer.
package time_report_pkg;

  localparam int FRAME_LEN = 10;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_QMARK = 8'h3F;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef struct packed {
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } time_digits_t;

  // Non-BCD digit values become '?' so a corrupt counter is visible on the wire.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? ASC_QMARK : (ASC_ZERO + {4'd0, d});
  endfunction

endpackage

// File: rtl/time_frame_char.sv
// Maps a frame byte index and a digit snapshot onto the "HH:MM:SS\r\n" character.
module time_frame_char
  import time_report_pkg::*;
(
  input  logic [3:0]   idx,
  input  time_digits_t digits,
  output logic [7:0]   frame_byte
);

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      4'd0:    frame_byte = digit_char(digits.hour1);
      4'd1:    frame_byte = digit_char(digits.hour0);
      4'd2:    frame_byte = ASC_COLON;
      4'd3:    frame_byte = digit_char(digits.min1);
      4'd4:    frame_byte = digit_char(digits.min0);
      4'd5:    frame_byte = ASC_COLON;
      4'd6:    frame_byte = digit_char(digits.sec1);
      4'd7:    frame_byte = digit_char(digits.sec0);
      4'd8:    frame_byte = ASC_CR;
      4'd9:    frame_byte = ASC_LF;
      default: frame_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/time_report_sched.sv
// Owns the UART TX FIFO write port: sends atomic time frames and fills idle
// cycles with echo bytes.
module time_report_sched
  import time_report_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ECHO_EN    = 1,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  auto_en,
  input  logic                  report_tick,
  input  logic                  report_req,
  input  logic [3:0]            hour1,
  input  logic [3:0]            hour0,
  input  logic [3:0]            min1,
  input  logic [3:0]            min0,
  input  logic [3:0]            sec1,
  input  logic [3:0]            sec0,
  input  logic                  echo_valid,
  input  logic [DATA_WIDTH-1:0] echo_data,
  output logic                  echo_ready,
  input  logic                  fifo_full,
  output logic                  fifo_we,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t       state;
  logic [3:0]   idx;
  logic         pending;
  time_digits_t snapshot;
  time_digits_t live;
  logic [7:0]   frame_byte;
  logic         trig;
  logic         frame_we;
  logic         last_byte;

  assign live      = {hour1, hour0, min1, min0, sec1, sec0};
  assign trig      = report_req | (auto_en & report_tick);
  assign busy      = (state == SEND);
  assign frame_we  = busy & ~fifo_full;
  assign last_byte = (idx == LAST_IDX);

  // Echo only gets the port when no frame is running or about to start.
  assign echo_ready = (ECHO_EN != 0) & rst & (state == IDLE) & ~trig & ~pending & ~fifo_full;
  assign fifo_we    = frame_we | (echo_valid & echo_ready);
  assign fifo_wdata = busy ? DATA_WIDTH'(frame_byte) : echo_data;

  time_frame_char u_char (
    .idx        (idx),
    .digits     (snapshot),
    .frame_byte (frame_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      pending    <= 1'b0;
      snapshot   <= '0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig || pending) begin
            snapshot <= live;
            idx      <= 4'd0;
            pending  <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (trig) begin
            if (pending) begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end else begin
              pending <= 1'b1;
            end
          end
          // A trigger landing on the last byte chains straight into the next frame.
          if (frame_we) begin
            if (last_byte) begin
              frame_done <= 1'b1;
              idx        <= 4'd0;
              if (pending || trig) begin
                snapshot <= live;
                pending  <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_report_sched.sv
// Directed bench for time_report_sched: frame bytes, stalls, triggers, echo, reset.
module tb_time_report_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       auto_en, report_tick, report_req;
  logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
  logic       echo_valid;
  logic [7:0] echo_data;
  logic       echo_ready;
  logic       fifo_full;
  logic       fifo_we;
  logic [7:0] fifo_wdata;
  logic       busy;
  logic       frame_done;
  logic [7:0] drop_cnt;

  int errorCount = 0;
  int checkCount = 0;

  logic [7:0] frameA [10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
  logic [7:0] frameB [10] = '{8'h36, 8'h35, 8'h3A, 8'h34, 8'h33, 8'h3A, 8'h32, 8'h31, 8'h0D, 8'h0A};
  logic [7:0] frameC [10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h3F, 8'h0D, 8'h0A};
  logic [7:0] expBytes [10];

  always #5 clk = ~clk;

  time_report_sched dut (
    .clk         (clk),
    .rst         (rst),
    .auto_en     (auto_en),
    .report_tick (report_tick),
    .report_req  (report_req),
    .hour1       (hour1),
    .hour0       (hour0),
    .min1        (min1),
    .min0        (min0),
    .sec1        (sec1),
    .sec0        (sec0),
    .echo_valid  (echo_valid),
    .echo_data   (echo_data),
    .echo_ready  (echo_ready),
    .fifo_full   (fifo_full),
    .fifo_we     (fifo_we),
    .fifo_wdata  (fifo_wdata),
    .busy        (busy),
    .frame_done  (frame_done),
    .drop_cnt    (drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                               input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    hour1 = h1; hour0 = h0; min1 = m1; min0 = m0; sec1 = s1; sec0 = s0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse report_req for one cycle; the frame's first byte appears in the following cycle.
  task automatic pulseReq();
    report_req = 1'b1;
    nextCycle();
    report_req = 1'b0;
  endtask

  // Called at the start of the cycle that should carry byte 0 of expBytes.
  task automatic sendFrame(input string tag, input int stallAt, input int stallLen,
                           input int trigA, input int trigB, input int chgAt, input logic expDone0);
    for (int k = 0; k < 10; k++) begin
      if (k == stallAt) begin
        fifo_full = 1'b1;
        for (int s = 0; s < stallLen; s++) begin
          @(negedge clk);
          checkOutput($sformatf("%s_stall%0d_we", tag, s), fifo_we, 0);
          checkOutput($sformatf("%s_stall%0d_busy", tag, s), busy, 1);
          nextCycle();
        end
        fifo_full = 1'b0;
      end
      report_req = (k == trigA) || (k == trigB);
      if (k == chgAt) applyStimulus(4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
      @(negedge clk);
      if (k == 0) checkOutput({tag, "_done0"}, frame_done, expDone0);
      checkOutput($sformatf("%s_we%0d", tag, k), fifo_we, 1);
      checkOutput($sformatf("%s_byte%0d", tag, k), fifo_wdata, expBytes[k]);
      checkOutput($sformatf("%s_erdy%0d", tag, k), echo_ready, 0);
      nextCycle();
      report_req = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (fifo_we && fifo_full) checkOutput("we_while_full", fifo_we, 0);
  end

  initial begin
    int writes;
    int doneSeen;

    rst = 1'b0;
    auto_en = 1'b0; report_tick = 1'b0; report_req = 1'b0;
    fifo_full = 1'b0;
    echo_valid = 1'b1; echo_data = 8'h55;
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

    // Reset state, with an echo byte offered to prove the port stays shut.
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_we", fifo_we, 0);
    checkOutput("rst_erdy", echo_ready, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    nextCycle();
    rst = 1'b1;
    echo_valid = 1'b0;
    nextCycle();

    $display("[TB] basic frame");
    expBytes = frameA;
    pulseReq();
    sendFrame("f1", -1, 0, -1, -1, -1, 1'b0);
    @(negedge clk);
    checkOutput("f1_done", frame_done, 1);
    checkOutput("f1_idle", busy, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("f1_done_once", frame_done, 0);
    nextCycle();

    $display("[TB] stalled frame");
    pulseReq();
    sendFrame("f2", 5, 3, -1, -1, -1, 1'b0);
    @(negedge clk);
    checkOutput("f2_done", frame_done, 1);
    nextCycle();

    $display("[TB] tick gating");
    report_tick = 1'b1;
    nextCycle();
    report_tick = 1'b0;
    writes = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      writes += int'(fifo_we) + int'(busy);
      nextCycle();
    end
    checkOutput("noauto_activity", writes, 0);

    auto_en = 1'b1;
    report_tick = 1'b1;
    report_req = 1'b1;
    nextCycle();
    report_tick = 1'b0;
    report_req = 1'b0;
    sendFrame("f3", -1, 0, -1, -1, -1, 1'b0);
    @(negedge clk);
    checkOutput("f3_done", frame_done, 1);
    writes = 0;
    nextCycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      writes += int'(fifo_we) + int'(busy);
      nextCycle();
    end
    checkOutput("f3_single_frame", writes, 0);
    checkOutput("f3_drop", drop_cnt, 0);
    auto_en = 1'b0;

    $display("[TB] back-to-back frames");
    pulseReq();
    sendFrame("f4a", -1, 0, 2, 4, 3, 1'b0);
    expBytes = frameB;
    sendFrame("f4b", -1, 0, -1, -1, -1, 1'b1);
    @(negedge clk);
    checkOutput("f4_done", frame_done, 1);
    checkOutput("f4_idle", busy, 0);
    checkOutput("f4_drop", drop_cnt, 1);
    nextCycle();

    $display("[TB] echo arbitration");
    echo_valid = 1'b1;
    echo_data = 8'h41;
    @(negedge clk);
    checkOutput("echo_rdy", echo_ready, 1);
    checkOutput("echo_we", fifo_we, 1);
    checkOutput("echo_data", fifo_wdata, 8'h41);
    nextCycle();
    report_req = 1'b1;
    @(negedge clk);
    checkOutput("echo_vs_trig_rdy", echo_ready, 0);
    checkOutput("echo_vs_trig_we", fifo_we, 0);
    nextCycle();
    report_req = 1'b0;
    sendFrame("f5", -1, 0, -1, -1, -1, 1'b0);
    @(negedge clk);
    checkOutput("f5_done", frame_done, 1);
    checkOutput("f5_echo_rdy", echo_ready, 1);
    checkOutput("f5_echo_we", fifo_we, 1);
    checkOutput("f5_echo_data", fifo_wdata, 8'h41);
    nextCycle();
    echo_valid = 1'b0;

    $display("[TB] reset mid-frame");
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    pulseReq();
    for (int k = 0; k < 5; k++) nextCycle();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_we", fifo_we, 0);
    checkOutput("midrst_drop", drop_cnt, 0);
    nextCycle();
    rst = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      doneSeen += int'(frame_done) + int'(fifo_we);
      nextCycle();
    end
    checkOutput("midrst_no_done", doneSeen, 0);

    $display("[TB] invalid digit");
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hA);
    expBytes = frameC;
    pulseReq();
    sendFrame("f6", -1, 0, -1, -1, -1, 1'b0);
    @(negedge clk);
    checkOutput("f6_done", frame_done, 1);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
